// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order issue to memory, outstanding-write tracking,
// fence barrier handshake and load alias detection. Define STORE_BUFFER_FWD_EN for load forwarding.
module store_buffer #(
  parameter int DEPTH           = 4,
  parameter int ADDR_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              st_valid_i,
  output logic              st_ready_o,
  input  logic [ADDR_W-1:0] st_addr_i,
  input  logic [31:0]       st_data_i,
  input  logic [3:0]        st_strb_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [31:0]       mem_req_data_o,
  output logic [3:0]        mem_req_strb_o,
  input  logic              mem_rsp_valid_i,
  input  logic              barrier_req_i,
  output logic              barrier_ack_o,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic              ld_hit_o,
  output logic              ld_fwd_valid_o,
  output logic [31:0]       ld_fwd_data_o,
  output logic              empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int OUT_W = 4;

  typedef enum logic [1:0] {IDLE, DRAIN, ACK} bar_state_e;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [3:0]        strb_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [OUT_W-1:0]  outstanding;
  bar_state_e        state;
  bar_state_e        state_next;
  logic              push;
  logic              pop;
  logic              rsp;
  logic              hit;
  logic [PTR_W-1:0]  idx;
  logic              unused_ld_lsb;
`ifdef STORE_BUFFER_FWD_EN
  logic [31:0]       young_data;
  logic [3:0]        young_strb;
`endif

  // Readiness depends only on registered state, never on mem_req_ready_i.
  assign st_ready_o      = (count < CNT_W'(DEPTH)) && (state == IDLE);
  assign mem_req_valid_o = (count != '0) && (outstanding < OUT_W'(MAX_OUTSTANDING));
  assign push            = st_valid_i && st_ready_o;
  assign pop             = mem_req_valid_o && mem_req_ready_i;
  assign rsp             = mem_rsp_valid_i && (outstanding != '0);
  assign mem_req_addr_o  = addr_q[rd_ptr];
  assign mem_req_data_o  = data_q[rd_ptr];
  assign mem_req_strb_o  = strb_q[rd_ptr];
  assign barrier_ack_o   = (state == ACK);
  assign empty_o         = (count == '0) && (outstanding == '0);
  assign ld_hit_o        = hit;
  assign unused_ld_lsb   = ^ld_addr_i[1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        strb_q[i] <= '0;
      end
    end else if (push) begin
      addr_q[wr_ptr] <= st_addr_i;
      data_q[wr_ptr] <= st_data_i;
      strb_q[wr_ptr] <= st_strb_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop) count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
      if (pop && !rsp) outstanding <= outstanding + OUT_W'(1);
      else if (!pop && rsp) outstanding <= outstanding - OUT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else state <= state_next;
  end

  // A withdrawn request aborts the drain even if it would have completed this cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (barrier_req_i) state_next = DRAIN;
      DRAIN: begin
        if (!barrier_req_i) state_next = IDLE;
        else if (empty_o) state_next = ACK;
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Walk oldest to youngest so the last match is the youngest aliasing store.
  always_comb begin
    hit = 1'b0;
    idx = rd_ptr;
`ifdef STORE_BUFFER_FWD_EN
    young_data = '0;
    young_strb = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < count) && (addr_q[idx][ADDR_W-1:2] == ld_addr_i[ADDR_W-1:2])) begin
        hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        young_data = data_q[idx];
        young_strb = strb_q[idx];
`endif
      end
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  assign ld_fwd_valid_o = hit && (young_strb == 4'hF);
  assign ld_fwd_data_o  = young_data;
`else
  assign ld_fwd_valid_o = 1'b0;
  assign ld_fwd_data_o  = '0;
`endif

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write store buffer between the execute stage's load/store path and the data memory port. It accepts retired stores and issues them to memory in order. It tracks outstanding writes and answers the fence unit's memory-barrier handshake once all earlier stores are globally performed. It also flags loads that alias a buffered store.

## Interface
- DEPTH, 4: store entries; power of two, 2..16
- ADDR_W, 32: address width
- MAX_OUTSTANDING, 4: issued-but-unacknowledged writes allowed, 1..15
- clk_i  in  1  system clock
- rst_ni  in  1  reset, asynchronous, active-low
- st_valid_i  in  1  store request
- st_ready_o  out  1  store accepted when valid & ready
- st_addr_i  in  ADDR_W  byte address
- st_data_i  in  32  store data, lane-aligned
- st_strb_i  in  4  byte enables
- mem_req_valid_o  out  1  write request to memory
- mem_req_ready_i  in  1  memory accepts request
- mem_req_addr_o  out  ADDR_W  write address
- mem_req_data_o  out  32  write data
- mem_req_strb_o  out  4  byte enables
- mem_rsp_valid_i  in  1  one write completion per pulse
- barrier_req_i  in  1  memory-barrier request from fence unit (level)
- barrier_ack_o  out  1  one-cycle barrier acknowledge
- ld_addr_i  in  ADDR_W  load address for alias check
- ld_hit_o  out  1  load word-aliases a buffered store
- ld_fwd_valid_o  out  1  forwarded data usable
- ld_fwd_data_o  out  32  forwarded data
- empty_o  out  1  no entries and no outstanding writes

## Operation
- Circular FIFO with write and read pointers, plus a count in 0..DEPTH.
- Push on st_valid_i & st_ready_o. Pop on mem_req_valid_o & mem_req_ready_i.
- st_ready_o = (count < DEPTH) & (barrier FSM == IDLE). It has no combinational path from mem_req_ready_i, so a full buffer refuses pushes even during a pop.
- mem_req_valid_o = (count != 0) & (outstanding < MAX_OUTSTANDING). Head fields drive mem_req_*_o directly.
- outstanding counter: +1 on pop, -1 on mem_rsp_valid_i; both in the same cycle leave it unchanged.
  - mem_rsp_valid_i while outstanding == 0 is ignored; the counter saturates at 0.
- Barrier FSM states: IDLE, DRAIN, ACK.
  - IDLE -> DRAIN when barrier_req_i is high.
  - DRAIN -> ACK when count == 0 and outstanding == 0, evaluated on registered values.
  - DRAIN -> IDLE if barrier_req_i drops (abort, no ack).
  - ACK -> IDLE unconditionally.
- barrier_ack_o = (state == ACK).
- Stores are blocked in DRAIN and ACK so the drain terminates.
- empty_o = (count == 0) & (outstanding == 0).
- Alias check compares ld_addr_i[ADDR_W-1:2] against every valid entry. ld_hit_o is combinational, and the load stage stalls on ld_hit_o & !ld_fwd_valid_o.

## Timing
- Reset values:
  - st_ready_o = 1, since the FSM is in IDLE.
  - mem_req_valid_o = 0 and mem_req_addr/data/strb = 0.
  - barrier_ack_o = 0, empty_o = 1, ld_hit_o = 0, ld_fwd_valid_o = 0, ld_fwd_data_o = 0.
- Storage array resets to zero. Reset mid-operation discards all entries and outstanding counts, and the FSM returns to IDLE.
- A store accepted in cycle N presents on mem_req_valid_o from N+1.
- mem_req_* is stable while valid & !ready.
- Barrier with empty buffer: request seen at edge N enters DRAIN. ACK follows at N+1, so barrier_ack_o is high for cycle N+2 only.
- barrier_ack_o never asserts for two consecutive cycles.
- Pointers wrap modulo DEPTH. Count reaching DEPTH is full; reaching 0 is empty.

## Configuration
- STORE_BUFFER_FWD_EN defined:
  - ld_fwd_valid_o = 1 when the youngest aliasing entry has strb == 4'hF.
  - ld_fwd_data_o = that entry's data.
  - Partial-strobe aliases give ld_hit_o = 1 and ld_fwd_valid_o = 0.
- Undefined: ld_fwd_valid_o and ld_fwd_data_o are tied to 0, and every alias stalls.

## Test plan
- Push 4 stores (0x100..0x10C, data 0xA0..0xA3) with mem_req_ready_i = 0:
  - st_ready_o drops after the 4th push.
  - Raising ready drains them in order on consecutive cycles.
- Barrier with 2 buffered stores, memory responding 3 cycles after each accept:
  - barrier_ack_o stays 0 until the 2nd response.
  - It then pulses for exactly 1 cycle, and st_ready_o is 0 throughout.
- MAX_OUTSTANDING = 2 with no responses:
  - mem_req_valid_o deasserts after 2 pops.
  - One mem_rsp_valid_i pulse reissues the next store.
- FWD_EN: buffer 0x200 with full strobes and data 0xDEADBEEF, then load 0x202.
  - Expect ld_hit_o = 1, ld_fwd_valid_o = 1, ld_fwd_data_o = 0xDEADBEEF.
  - With strb 4'h3 instead: ld_hit_o = 1, ld_fwd_valid_o = 0.
- Same-cycle pop and mem_rsp_valid_i at outstanding = 1: outstanding stays 1.
- Assert rst_ni low with 3 entries and 2 outstanding:
  - empty_o = 1 and mem_req_valid_o = 0 immediately.
  - Barrier after release acks in 2 cycles.
